bulls_cows_ng: RTL and testbench
================================

Name: bulls_cows_ng

Overview:
Parametrised two-player Bulls & Cows game controller. It generalises the fixed 4-digit game to DIGITS digits of DIGIT_W bits in base BASE, with a round limit. It adds entry validation, an equalising last turn, and draw detection. It sits between the board's switch/button front end (guess, confirm) and the display decoders (state, bulls, cows, winner).

Parameters:
DIGITS, 4, number of digits per secret/guess (2..8)
DIGIT_W, 4, bits per digit
BASE, 10, digit legal range 0..BASE-1 (BASE <= 2**DIGIT_W)
MAX_ROUNDS, 15, completed rounds after which an unresolved game is a draw (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
guess  in  DIGITS*DIGIT_W  secret/guess entry; digit k = guess[k*DIGIT_W +: DIGIT_W]
confirm  in  1  level button, synchronous to clock; acted on at rising edge only
state  out  3  0 SECRET_J1, 1 SECRET_J2, 2 GUESS_J1, 3 GUESS_J2, 4 WIN, 5 DRAW
player  out  1  active player: 0 = J1, 1 = J2
bulls  out  $clog2(DIGITS+1)  bulls of last valid guess
cows  out  $clog2(DIGITS+1)  cows of last valid guess
round  out  $clog2(MAX_ROUNDS+1)  completed rounds
winner  out  2  00 none/exhausted, 01 J1, 10 J2, 11 both
result_valid  out  1  one-cycle pulse when bulls/cows update
invalid  out  1  one-cycle pulse when an entry is rejected

Behaviour:
- Reset (async): state SECRET_J1; player, bulls, cows, round, winner, result_valid, invalid = 0; secrets cleared; j1_hit = 0.
- confirm_q resets to 1. confirm_pulse = confirm & ~confirm_q. A confirm held high through reset release is ignored until it drops.
- All actions occur on the clock edge where confirm_pulse = 1; outputs are registered (1-cycle latency from pulse).
- Validation applies in SECRET_* and GUESS_*. Entry is valid iff every digit < BASE and all digits are pairwise distinct.
- Invalid entry: invalid pulses; state, bulls, cows, round and secrets are unchanged.
- SECRET_J1 -> store secret_j1 -> SECRET_J2 -> store secret_j2 -> GUESS_J1.
- GUESS_J1 evaluates against secret_j2; GUESS_J2 evaluates against secret_j1.
- bulls = count of k with g[k]==s[k].
- cows = count of (i,j), i!=j, with g[i]==s[j].
- Computed combinationally from the current entry. The win check uses these fresh values, never the previously registered bulls.
- On each evaluation: bulls/cows registered and result_valid pulses.
- GUESS_J1 -> GUESS_J2 always. If bulls==DIGITS, set j1_hit (equalising turn for J2).
- GUESS_J2 outcome, with hit2 = (bulls==DIGITS):
  - j1_hit & hit2 -> DRAW, winner 11.
  - j1_hit only -> WIN, winner 01.
  - hit2 only -> WIN, winner 10.
  - neither: round += 1. If the new round == MAX_ROUNDS -> DRAW, winner 00; else -> GUESS_J1.
- round increments only on a non-terminal J2 evaluation and saturates at MAX_ROUNDS.
- player = 0 in SECRET_J1/GUESS_J1, 1 in SECRET_J2/GUESS_J2. It holds its last value in WIN/DRAW.
- WIN/DRAW: guess is not validated. confirm_pulse -> SECRET_J1 and clears bulls, cows, round, winner, j1_hit, secrets and player.
- State encodings 6..7 are unreachable; if entered, go to SECRET_J1 on the next clock.
- Reset mid-operation aborts the game immediately with no partial result.

Test Plan:
1. Secrets 0x1234 / 0x5678; J1 guesses 0x8765 -> bulls 0, cows 4, result_valid 1 cycle, state 3, player 1.
2. Secret entry 0x1123, then 0x12A4 -> invalid pulses each time, state stays 0. Then 0x1234 accepted -> state 1.
3. J1 guesses 0x5678 (4 bulls) -> state 3, winner 00. J2 guesses 0x1243 -> bulls 2, cows 2, state 4, winner 01.
4. J1 guesses 0x5678, then J2 guesses 0x1234 -> state 5, winner 11. Next confirm -> state 0, all outputs 0.
5. MAX_ROUNDS=2, four non-winning guesses -> round 1 after the 2nd guess. After the 4th: state 5, winner 00, round 2.
6. confirm held high 5 cycles in GUESS_J1 -> exactly one evaluation. Reset asserted in GUESS_J2 with confirm high -> state 0, outputs 0, and no action until confirm falls and rises again.

Source files
------------

// File: rtl/bulls_cows_ng_if.sv
// Front-end / display bundle of the Bulls & Cows controller.
// The master side drives guess/confirm and the slave side drives the results.
interface bulls_cows_ng_if #(
   parameter int DIGITS     = 4,
   parameter int DIGIT_W    = 4,
   parameter int MAX_ROUNDS = 15
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int RW = $clog2(MAX_ROUNDS + 1);

   logic [DIGITS*DIGIT_W-1:0] guess;
   logic                      confirm;
   logic [2:0]                state;
   logic                      player;
   logic [CW-1:0]             bulls;
   logic [CW-1:0]             cows;
   logic [RW-1:0]             round;
   logic [1:0]                winner;
   logic                      result_valid;
   logic                      invalid;

   modport master (
      output guess, confirm,
      input  state, player, bulls, cows, round, winner, result_valid, invalid
   );

   modport slave (
      input  guess, confirm,
      output state, player, bulls, cows, round, winner, result_valid, invalid
   );
endinterface

// File: rtl/bulls_cows_ng.sv
// Two-player Bulls & Cows controller: validated secret/guess entry, an equalising
// last turn for J2, and a draw after MAX_ROUNDS unresolved rounds.
module bulls_cows_ng #(
   parameter int DIGITS     = 4,
   parameter int DIGIT_W    = 4,
   parameter int BASE       = 10,
   parameter int MAX_ROUNDS = 15
) (
   input logic           clock,
   input logic           reset,
   bulls_cows_ng_if.slave bus
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int RW = $clog2(MAX_ROUNDS + 1);
   localparam int GW = DIGITS * DIGIT_W;
   localparam logic [DIGIT_W:0] BASE_L = (DIGIT_W + 1)'(BASE);

   typedef enum logic [2:0] {
      SECRET_J1 = 3'd0,
      SECRET_J2 = 3'd1,
      GUESS_J1  = 3'd2,
      GUESS_J2  = 3'd3,
      WIN       = 3'd4,
      DRAW      = 3'd5
   } state_t;

   state_t        r_state,        w_state_nxt;
   logic          r_player,       w_player_nxt;
   logic [CW-1:0] r_bulls,        w_bulls_nxt;
   logic [CW-1:0] r_cows,         w_cows_nxt;
   logic [RW-1:0] r_round,        w_round_nxt;
   logic [1:0]    r_winner,       w_winner_nxt;
   logic          r_result_valid, w_result_valid_nxt;
   logic          r_invalid,      w_invalid_nxt;
   logic [GW-1:0] r_secret_j1,    w_secret_j1_nxt;
   logic [GW-1:0] r_secret_j2,    w_secret_j2_nxt;
   logic          r_j1_hit,       w_j1_hit_nxt;
   logic          r_confirm_q;

   logic          w_pulse;
   logic [GW-1:0] w_secret;
   logic          w_valid;
   logic [CW-1:0] w_bulls;
   logic [CW-1:0] w_cows;
   logic          w_hit;
   logic [RW-1:0] w_round_inc;

   assign w_pulse     = bus.confirm & ~r_confirm_q;
   assign w_secret    = (r_state == GUESS_J1) ? r_secret_j2 : r_secret_j1;
   assign w_hit       = (w_bulls == CW'(DIGITS));
   assign w_round_inc = r_round + RW'(1);

   // Score and validity of the entry currently on the switches
   always_comb begin
      w_valid = 1'b1;
      w_bulls = '0;
      w_cows  = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ({1'b0, bus.guess[i*DIGIT_W +: DIGIT_W]} >= BASE_L)
            w_valid = 1'b0;
         if (bus.guess[i*DIGIT_W +: DIGIT_W] == w_secret[i*DIGIT_W +: DIGIT_W])
            w_bulls = w_bulls + CW'(1);
         for (int unsigned j = 0; j < DIGITS; j++) begin
            if (i != j && bus.guess[i*DIGIT_W +: DIGIT_W] == w_secret[j*DIGIT_W +: DIGIT_W])
               w_cows = w_cows + CW'(1);
            if (j > i && bus.guess[i*DIGIT_W +: DIGIT_W] == bus.guess[j*DIGIT_W +: DIGIT_W])
               w_valid = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_player_nxt       = r_player;
      w_bulls_nxt        = r_bulls;
      w_cows_nxt         = r_cows;
      w_round_nxt        = r_round;
      w_winner_nxt       = r_winner;
      w_result_valid_nxt = 1'b0;
      w_invalid_nxt      = 1'b0;
      w_secret_j1_nxt    = r_secret_j1;
      w_secret_j2_nxt    = r_secret_j2;
      w_j1_hit_nxt       = r_j1_hit;
      case (r_state)
         SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2: begin
            if (w_pulse && !w_valid) begin
               w_invalid_nxt = 1'b1;
            end else if (w_pulse) begin
               case (r_state)
                  SECRET_J1: begin
                     w_secret_j1_nxt = bus.guess;
                     w_state_nxt     = SECRET_J2;
                     w_player_nxt    = 1'b1;
                  end
                  SECRET_J2: begin
                     w_secret_j2_nxt = bus.guess;
                     w_state_nxt     = GUESS_J1;
                     w_player_nxt    = 1'b0;
                  end
                  GUESS_J1: begin
                     w_bulls_nxt        = w_bulls;
                     w_cows_nxt         = w_cows;
                     w_result_valid_nxt = 1'b1;
                     w_state_nxt        = GUESS_J2;
                     w_player_nxt       = 1'b1;
                     if (w_hit)
                        w_j1_hit_nxt = 1'b1;
                  end
                  default: begin
                     w_bulls_nxt        = w_bulls;
                     w_cows_nxt         = w_cows;
                     w_result_valid_nxt = 1'b1;
                     if (r_j1_hit && w_hit) begin
                        w_state_nxt  = DRAW;
                        w_winner_nxt = 2'b11;
                     end else if (r_j1_hit) begin
                        w_state_nxt  = WIN;
                        w_winner_nxt = 2'b01;
                     end else if (w_hit) begin
                        w_state_nxt  = WIN;
                        w_winner_nxt = 2'b10;
                     end else if (r_round != RW'(MAX_ROUNDS)) begin
                        w_round_nxt = w_round_inc;
                        if (w_round_inc == RW'(MAX_ROUNDS)) begin
                           w_state_nxt  = DRAW;
                           w_winner_nxt = 2'b00;
                        end else begin
                           w_state_nxt  = GUESS_J1;
                           w_player_nxt = 1'b0;
                        end
                     end
                  end
               endcase
            end
         end
         WIN, DRAW: begin
            if (w_pulse) begin
               w_state_nxt     = SECRET_J1;
               w_player_nxt    = 1'b0;
               w_bulls_nxt     = '0;
               w_cows_nxt      = '0;
               w_round_nxt     = '0;
               w_winner_nxt    = 2'b00;
               w_secret_j1_nxt = '0;
               w_secret_j2_nxt = '0;
               w_j1_hit_nxt    = 1'b0;
            end
         end
         default: w_state_nxt = SECRET_J1;
      endcase
   end

   // confirm_q resets high so a button held through reset is not seen as a press
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= SECRET_J1;
         r_player       <= 1'b0;
         r_bulls        <= '0;
         r_cows         <= '0;
         r_round        <= '0;
         r_winner       <= 2'b00;
         r_result_valid <= 1'b0;
         r_invalid      <= 1'b0;
         r_secret_j1    <= '0;
         r_secret_j2    <= '0;
         r_j1_hit       <= 1'b0;
         r_confirm_q    <= 1'b1;
      end else begin
         r_state        <= w_state_nxt;
         r_player       <= w_player_nxt;
         r_bulls        <= w_bulls_nxt;
         r_cows         <= w_cows_nxt;
         r_round        <= w_round_nxt;
         r_winner       <= w_winner_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_invalid      <= w_invalid_nxt;
         r_secret_j1    <= w_secret_j1_nxt;
         r_secret_j2    <= w_secret_j2_nxt;
         r_j1_hit       <= w_j1_hit_nxt;
         r_confirm_q    <= bus.confirm;
      end
   end

   assign bus.state        = r_state;
   assign bus.player       = r_player;
   assign bus.bulls        = r_bulls;
   assign bus.cows         = r_cows;
   assign bus.round        = r_round;
   assign bus.winner       = r_winner;
   assign bus.result_valid = r_result_valid;
   assign bus.invalid      = r_invalid;
endmodule

// File: tb/tb_bulls_cows_ng.sv
// Directed bench for bulls_cows_ng: a default instance and a MAX_ROUNDS=2 instance
// driven from one vector table, plus sequences for held confirm and mid-game reset.
module tb_bulls_cows_ng;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clock = ~clock;

   bulls_cows_ng_if #(.DIGITS(4), .DIGIT_W(4), .MAX_ROUNDS(15)) bus1 ();
   bulls_cows_ng_if #(.DIGITS(4), .DIGIT_W(4), .MAX_ROUNDS(2))  bus2 ();

   bulls_cows_ng #(.DIGITS(4), .DIGIT_W(4), .BASE(10), .MAX_ROUNDS(15)) u_dut1 (
      .clock(clock), .reset(reset), .bus(bus1.slave)
   );
   bulls_cows_ng #(.DIGITS(4), .DIGIT_W(4), .BASE(10), .MAX_ROUNDS(2)) u_dut2 (
      .clock(clock), .reset(reset), .bus(bus2.slave)
   );

   typedef struct {
      int          dut;
      logic [15:0] g;
      int          st, pl, b, c, rnd, win, rv, inv;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int dut, input logic [15:0] g, input int st, input int pl,
                      input int b, input int c, input int rnd, input int win,
                      input int rv, input int inv);
      vec_t v;
      v.dut = dut; v.g = g; v.st = st; v.pl = pl; v.b = b; v.c = c;
      v.rnd = rnd; v.win = win; v.rv = rv; v.inv = inv;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input int d, input logic [15:0] g);
      @(negedge clock);
      if (d == 0) begin bus1.guess = g; bus1.confirm = 1'b1; end
      else        begin bus2.guess = g; bus2.confirm = 1'b1; end
      @(posedge clock);
      #1;
   endtask

   task automatic release_btn();
      @(negedge clock);
      bus1.confirm = 1'b0;
      bus2.confirm = 1'b0;
      @(posedge clock);
   endtask

   task automatic sample(input int d, output int st, output int pl, output int b,
                         output int c, output int rnd, output int win,
                         output int rv, output int inv);
      if (d == 0) begin
         st = bus1.state; pl = bus1.player; b = bus1.bulls; c = bus1.cows;
         rnd = bus1.round; win = bus1.winner; rv = bus1.result_valid; inv = bus1.invalid;
      end else begin
         st = bus2.state; pl = bus2.player; b = bus2.bulls; c = bus2.cows;
         rnd = bus2.round; win = bus2.winner; rv = bus2.result_valid; inv = bus2.invalid;
      end
   endtask

   task automatic check_all(input string tag, input int d, input int st, input int pl,
                            input int b, input int c, input int rnd, input int win,
                            input int rv, input int inv);
      int a_st, a_pl, a_b, a_c, a_rnd, a_win, a_rv, a_inv;
      sample(d, a_st, a_pl, a_b, a_c, a_rnd, a_win, a_rv, a_inv);
      check({tag, ".state"},        a_st,  st);
      check({tag, ".player"},       a_pl,  pl);
      check({tag, ".bulls"},        a_b,   b);
      check({tag, ".cows"},         a_c,   c);
      check({tag, ".round"},        a_rnd, rnd);
      check({tag, ".winner"},       a_win, win);
      check({tag, ".result_valid"}, a_rv,  rv);
      check({tag, ".invalid"},      a_inv, inv);
   endtask

   initial begin
      int rv_cnt;
      int inv_cnt;

      bus1.guess = '0; bus1.confirm = 1'b0;
      bus2.guess = '0; bus2.confirm = 1'b0;

      //   dut guess     st pl b  c  rnd win rv inv
      add(0, 16'h1123,  0, 0, 0, 0, 0,  0,  0, 1);
      add(0, 16'h12A4,  0, 0, 0, 0, 0,  0,  0, 1);
      add(0, 16'h1234,  1, 1, 0, 0, 0,  0,  0, 0);
      add(0, 16'h5678,  2, 0, 0, 0, 0,  0,  0, 0);
      add(0, 16'h8765,  3, 1, 0, 4, 0,  0,  1, 0);
      add(0, 16'h1224,  3, 1, 0, 4, 0,  0,  0, 1);
      add(0, 16'h9087,  2, 0, 0, 0, 1,  0,  1, 0);
      add(0, 16'h5678,  3, 1, 4, 0, 1,  0,  1, 0);
      add(0, 16'h1243,  4, 1, 2, 2, 1,  1,  1, 0);
      add(0, 16'hFFFF,  0, 0, 0, 0, 0,  0,  0, 0);
      add(0, 16'h1234,  1, 1, 0, 0, 0,  0,  0, 0);
      add(0, 16'h5678,  2, 0, 0, 0, 0,  0,  0, 0);
      add(0, 16'h5678,  3, 1, 4, 0, 0,  0,  1, 0);
      add(0, 16'h1234,  5, 1, 4, 0, 0,  3,  1, 0);
      add(0, 16'h0000,  0, 0, 0, 0, 0,  0,  0, 0);
      add(0, 16'h1234,  1, 1, 0, 0, 0,  0,  0, 0);
      add(0, 16'h5678,  2, 0, 0, 0, 0,  0,  0, 0);
      add(0, 16'h0123,  3, 1, 0, 0, 0,  0,  1, 0);
      add(0, 16'h1234,  4, 1, 4, 0, 0,  2,  1, 0);
      add(0, 16'h3210,  0, 0, 0, 0, 0,  0,  0, 0);
      add(1, 16'h1234,  1, 1, 0, 0, 0,  0,  0, 0);
      add(1, 16'h5678,  2, 0, 0, 0, 0,  0,  0, 0);
      add(1, 16'h0123,  3, 1, 0, 0, 0,  0,  1, 0);
      add(1, 16'h9087,  2, 0, 0, 0, 1,  0,  1, 0);
      add(1, 16'h0123,  3, 1, 0, 0, 1,  0,  1, 0);
      add(1, 16'h9087,  5, 1, 0, 0, 2,  0,  1, 0);
      add(1, 16'h1234,  0, 0, 0, 0, 0,  0,  0, 0);

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check_all("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_all("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         press(vecs[i].dut, vecs[i].g);
         check_all($sformatf("v%0d", i), vecs[i].dut, vecs[i].st, vecs[i].pl, vecs[i].b,
                   vecs[i].c, vecs[i].rnd, vecs[i].win, vecs[i].rv, vecs[i].inv);
         release_btn();
         #1;
         check($sformatf("v%0d.rv_drop", i),
               (vecs[i].dut == 0) ? int'(bus1.result_valid) : int'(bus2.result_valid), 0);
      end

      // confirm held high for five cycles in GUESS_J1 acts once
      press(0, 16'h1234); release_btn();
      press(0, 16'h5678); release_btn();
      @(negedge clock);
      bus1.guess = 16'h8765;
      bus1.confirm = 1'b1;
      rv_cnt = 0;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (bus1.result_valid) rv_cnt++;
      end
      check("hold.evals", rv_cnt, 1);
      check_all("hold", 0, 3, 1, 0, 4, 0, 0, 0, 0);
      release_btn();

      // reset in GUESS_J2 with confirm high; confirm must fall before acting again
      @(negedge clock);
      bus1.guess = 16'h9087;
      bus1.confirm = 1'b1;
      reset = 1'b1;
      #1;
      check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
      inv_cnt = 0;
      repeat (3) begin
         @(posedge clock);
         #1;
         if (bus1.invalid || bus1.result_valid || bus1.state != 3'd0) inv_cnt++;
      end
      check("rst_held.no_action", inv_cnt, 0);
      check_all("rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      release_btn();
      press(0, 16'h9087);
      check_all("rst_repress", 0, 1, 1, 0, 0, 0, 0, 0, 0);
      release_btn();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
